// File: rtl/demux1x2_8bit_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux1x2_8bit_stream_pkg
//   Shared definitions for the 1-to-2 stream demultiplexer:
//   - default data / counter widths
//   - named steering and mode constants
//   - the two-state holding-slot state type
//   - a helper that says whether a slot can take a new word this cycle
// -----------------------------------------------------------------------------
package demux1x2_8bit_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Target output selection values
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    // Steering mode values
    localparam logic MODE_SEL = 1'b0;   // route by inSel
    localparam logic MODE_ALT = 1'b1;   // alternate out0, out1, out0, ...

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // A slot can take a word when it is empty, or when its current word is
    // leaving on this same edge (pass-through refill).
    function automatic logic slot_can_take(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/demux1x2_8bit_stream_out_slot_reg.sv
// -----------------------------------------------------------------------------
// demux1x2_8bit_stream_out_slot_reg
//   One-entry valid/ready holding register with a handshake counter.
//   The upstream logic only asserts load when the slot can take a word
//   (empty, or draining on the same edge).
//
// Ports:
//   clk        in   clock, rising edge
//   rstN       in   asynchronous active-low reset
//   load       in   write load_data into the slot on the next edge
//   load_data  in   [WIDTH] word to store
//   out_valid  out  slot holds a word
//   out_data   out  [WIDTH] held word
//   out_ready  in   consumer takes the word this cycle
//   cnt        out  [CNT_W] completed output handshakes, wraps
// -----------------------------------------------------------------------------
module demux1x2_8bit_stream_out_slot_reg
    import demux1x2_8bit_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drain;

    assign drain = (state_q == SLOT_FULL) && out_ready;

    // Fill wins over drain: a refill on the draining edge keeps the slot full.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        if (load) begin
            state_d = SLOT_FULL;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rstN) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data is cleared on reset so the output bus reads zero until first fill.
    always_ff @(posedge clk or negedge rstN) begin
        // NOTE: this is a single register, not a memory array, so an async
        // clear costs nothing and gives a deterministic output after reset.
        if (!rstN) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else if (drain) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/demux1x2_8bit_stream.sv
// -----------------------------------------------------------------------------
// demux1x2_8bit_stream
//   Registered 1-to-2 demultiplexer with valid/ready on the input and on both
//   outputs. Routes serialized products of the shared multiplier back to the
//   real-path (out0) and imaginary-path (out1) accumulators. Each output owns
//   a one-entry holding slot, so a stalled output only blocks words aimed at
//   it; the other output keeps flowing.
//
// Ports:
//   clk        in   clock, rising edge
//   rstN       in   asynchronous active-low reset
//   mode       in   0 = route by inSel, 1 = alternate starting at out0
//   inValid    in   input word present
//   inData     in   [WIDTH] input word
//   inSel      in   target when mode=0 (0 = out0, 1 = out1)
//   inReady    out  input word accepted this cycle (independent of inValid)
//   out0Valid  out  out0 slot holds a word
//   out0Data   out  [WIDTH] out0 word
//   out0Ready  in   consumer 0 takes the word
//   out1Valid  out  out1 slot holds a word
//   out1Data   out  [WIDTH] out1 word
//   out1Ready  in   consumer 1 takes the word
//   cnt0       out  [CNT_W] completed out0 handshakes, wraps
//   cnt1       out  [CNT_W] completed out1 handshakes, wraps
// -----------------------------------------------------------------------------
module demux1x2_8bit_stream
    import demux1x2_8bit_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             mode,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    input  logic             inSel,
    output logic             inReady,
    output logic             out0Valid,
    output logic [WIDTH-1:0] out0Data,
    input  logic             out0Ready,
    output logic             out1Valid,
    output logic [WIDTH-1:0] out1Data,
    input  logic             out1Ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic alt_ptr;
    logic tgt;
    logic accept;
    logic load0;
    logic load1;

    assign tgt = (mode == MODE_ALT) ? alt_ptr : inSel;

    // Ready depends only on the targeted slot, never on the other one.
    assign inReady = (tgt == SEL_OUT0) ? slot_can_take(out0Valid, out0Ready)
                                       : slot_can_take(out1Valid, out1Ready);

    assign accept = inValid && inReady;
    assign load0  = accept && (tgt == SEL_OUT0);
    assign load1  = accept && (tgt == SEL_OUT1);

    // Alternate pointer: cleared whenever the block is in select mode so the
    // first word after entering alternate mode always goes to out0; advances
    // only on an accepted word.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            alt_ptr <= SEL_OUT0;
        end else if (mode == MODE_SEL) begin
            alt_ptr <= SEL_OUT0;
        end else if (accept) begin
            alt_ptr <= ~alt_ptr;
        end
    end

    demux1x2_8bit_stream_out_slot_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rstN      (rstN),
        .load      (load0),
        .load_data (inData),
        .out_valid (out0Valid),
        .out_data  (out0Data),
        .out_ready (out0Ready),
        .cnt       (cnt0)
    );

    demux1x2_8bit_stream_out_slot_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rstN      (rstN),
        .load      (load1),
        .load_data (inData),
        .out_valid (out1Valid),
        .out_data  (out1Data),
        .out_ready (out1Ready),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux1x2_8bit_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1x2_8bit_stream
//   Scoreboard bench. The driver applies inputs at the falling edge, predicts
//   inReady from the reference model (per-output queues of words in flight
//   plus a model alternate pointer) and pushes accepted words into the queue
//   of the output the rules select. An independent monitor compares every
//   valid output word with the queue head and pops on each handshake.
// -----------------------------------------------------------------------------
module tb_demux1x2_8bit_stream;

    logic       clk;
    logic       rstN;
    logic       mode;
    logic       inValid;
    logic [7:0] inData;
    logic       inSel;
    logic       inReady;
    logic       out0Valid;
    logic [7:0] out0Data;
    logic       out0Ready;
    logic       out1Valid;
    logic [7:0] out1Data;
    logic       out1Ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    demux1x2_8bit_stream dut (
        .clk       (clk),
        .rstN      (rstN),
        .mode      (mode),
        .inValid   (inValid),
        .inData    (inData),
        .inSel     (inSel),
        .inReady   (inReady),
        .out0Valid (out0Valid),
        .out0Data  (out0Data),
        .out0Ready (out0Ready),
        .out1Valid (out1Valid),
        .out1Data  (out1Data),
        .out1Ready (out1Ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         pops0    = 0;
    int         pops1    = 0;
    logic       alt_m    = 1'b0;
    bit         mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 3 time units after the falling edge, before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                check("cnt0", {24'd0, cnt0}, 32'(pops0 & 255));
                check("cnt1", {24'd0, cnt1}, 32'(pops1 & 255));
                if (out0Valid) begin
                    if (exp0.size() == 0) begin
                        check("out0_spurious_valid", 32'd1, 32'd0);
                    end else begin
                        check("out0_data", {24'd0, out0Data}, {24'd0, exp0[0]});
                        if (out0Ready) begin
                            void'(exp0.pop_front());
                            pops0++;
                        end
                    end
                end
                if (out1Valid) begin
                    if (exp1.size() == 0) begin
                        check("out1_spurious_valid", 32'd1, 32'd0);
                    end else begin
                        check("out1_data", {24'd0, out1Data}, {24'd0, exp1[0]});
                        if (out1Ready) begin
                            void'(exp1.pop_front());
                            pops1++;
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus. Queue sizes at this point equal slot occupancy.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic m,
                        input logic r0, input logic r1, output bit acc);
        logic tgt;
        logic exp_rdy;
        @(negedge clk);
        inValid   = v;
        inData    = d;
        inSel     = s;
        mode      = m;
        out0Ready = r0;
        out1Ready = r1;
        #2;
        tgt     = m ? alt_m : s;
        exp_rdy = tgt ? ((exp1.size() == 0) || r1) : ((exp0.size() == 0) || r0);
        check("in_ready", {31'd0, inReady}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        if (acc) begin
            if (tgt) exp1.push_back(d);
            else     exp0.push_back(d);
        end
        if (!m)       alt_m = 1'b0;
        else if (acc) alt_m = ~alt_m;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic m,
                        input logic r0, input logic r1);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            step(1'b1, d, s, m, r0, r1, a);
            n++;
        end
        if (!a) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, a);
            n++;
        end
        check("drain_empty", 32'(exp0.size() + exp1.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         a;
        int         c0;
        int         c1;
        bit         hold;
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       m;

        // ---------------- reset with inValid asserted ----------------
        rstN = 1'b0; mode = 1'b0; inValid = 1'b1; inData = 8'h99; inSel = 1'b0;
        out0Ready = 1'b0; out1Ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out0_valid", {31'd0, out0Valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1Valid}, 32'd0);
        check("rst_out0_data",  {24'd0, out0Data},  32'd0);
        check("rst_cnt0",       {24'd0, cnt0},      32'd0);
        check("rst_cnt1",       {24'd0, cnt1},      32'd0);
        inValid = 1'b0;
        @(negedge clk);
        rstN   = 1'b1;
        mon_en = 1'b1;

        // ---------------- mode 0 directed ----------------
        send(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check("dir_cnt0", {24'd0, cnt0}, 32'd1);
        check("dir_cnt1", {24'd0, cnt1}, 32'd1);

        // ---------------- back-pressure on out1 ----------------
        c1 = pops1;
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send(8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, a);
        check("bp_out1_held", {31'd0, out1Valid}, 32'd1);
        send(8'h7E, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check("bp_cnt1", {24'd0, cnt1}, 32'((c1 + 2) & 255));

        // ---------------- alternate mode ----------------
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 1'b1, a);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, a);
        send(8'h05, 1'b1, 1'b1, 1'b1, 1'b1);
        drain();

        // ---------------- pass-through refill ----------------
        c0 = pops0;
        send(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, a);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, a);
        check("refill_valid", {31'd0, out0Valid}, 32'd1);
        check("refill_data",  {24'd0, out0Data},  32'h55);
        check("refill_cnt0",  {24'd0, cnt0},      32'((c0 + 1) & 255));
        drain();

        // ---------------- reset mid-operation ----------------
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h82, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, a);
        mon_en = 1'b0;
        rstN   = 1'b0;
        #1;
        check("midrst_out0_valid", {31'd0, out0Valid}, 32'd0);
        check("midrst_out1_valid", {31'd0, out1Valid}, 32'd0);
        check("midrst_cnt0",       {24'd0, cnt0},      32'd0);
        check("midrst_cnt1",       {24'd0, cnt1},      32'd0);
        exp0.delete();
        exp1.delete();
        pops0 = 0;
        pops1 = 0;
        alt_m = 1'b0;
        @(negedge clk);
        rstN   = 1'b1;
        mon_en = 1'b1;

        // ---------------- counter wrap ----------------
        for (int i = 0; i < 256; i++) begin
            send(8'(i * 7), 1'b0, 1'b0, 1'b1, 1'b1);
        end
        drain();
        check("wrap_cnt0", {24'd0, cnt0}, 32'd0);

        // ---------------- randomized traffic ----------------
        hold = 1'b0;
        v = 1'b0; d = 8'h00; s = 1'b0; m = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                d = 8'($urandom);
                s = 1'($urandom);
                if ($urandom_range(0, 15) == 0) m = ~m;
            end
            step(v, d, s, m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), a);
            hold = v && !a;
        end
        drain();
        check("final_out0_idle", {31'd0, out0Valid}, 32'd0);
        check("final_out1_idle", {31'd0, out1Valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
